// File: rtl/uart_tx_buffer_if.sv
// Bus bundle for uart_tx_buffer: 68k CPU register port plus the drain-side
// master port toward the uart register interface.
interface uart_tx_buffer_if;
  logic [15:0] data_write;
  logic [15:0] data_read;
  logic [7:0]  addr;
  logic        uds;
  logic        lds;
  logic        rw;
  logic        ack;
  logic [15:0] u_data_write;
  logic [7:0]  u_addr;
  logic        u_uds;
  logic        u_lds;
  logic        u_rw;
  logic        u_ack;
  logic        fifo_empty;
  logic        busy;

  modport master (
    output data_write, addr, uds, lds, rw, u_ack,
    input  data_read, ack, u_data_write, u_addr, u_uds, u_lds, u_rw, fifo_empty, busy
  );

  modport slave (
    input  data_write, addr, uds, lds, rw, u_ack,
    output data_read, ack, u_data_write, u_addr, u_uds, u_lds, u_rw, fifo_empty, busy
  );
endinterface

// File: rtl/uart_tx_buffer.sv
// Transmit byte FIFO between the 68k bus and the uart: the CPU pushes bytes,
// and a small drain FSM writes them one per frame into the uart TX register.
module uart_tx_buffer #(
  parameter int         DEPTH_LOG2   = 4,
  parameter logic [7:0] UART_TX_ADDR = 8'h02
) (
  input logic             clk,
  input logic             reset,
  uart_tx_buffer_if.slave bus
);
  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int CNT_W = DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

  state_t                state, state_nxt;
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  overflow;
  logic                  full, empty;
  logic [6:0]            reg_sel;
  logic                  cpu_hit, push, flush, cnt_rd, stat_rd;
  logic                  pop, push_ok, load_head, lds_nxt;
  logic [15:0]           rd_data;
  logic [15:0]           data_read_r;
  logic                  ack_r, u_lds_r;
  logic [15:0]           u_data_r;
  logic                  unused_bits;

  assign unused_bits = ^{bus.data_write[7:0], bus.addr[0]};

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign reg_sel = bus.addr[7:1];
  assign cpu_hit = bus.uds | bus.lds;
  assign push    = bus.lds & ~bus.rw & (reg_sel == 7'd1);
  assign cnt_rd  = bus.lds &  bus.rw & (reg_sel == 7'd2);
  assign stat_rd = bus.lds &  bus.rw & (reg_sel == 7'd3);
  assign flush   = bus.lds & ~bus.rw & (reg_sel == 7'd3) & bus.data_write[8];

  // A pop only counts when a real request is being acknowledged; after a flush
  // the in-flight byte is still sent but there is nothing left to pop.
  assign pop     = (state == REQ) & u_lds_r & bus.u_ack & ~empty;
  assign push_ok = push & (~full | pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
        if (pop)     rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
        case ({push_ok, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
      if (push & full & ~pop) overflow <= 1'b1;
      else if (stat_rd)       overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= bus.data_write[15:8];
  end

  always_comb begin
    rd_data = '0;
    if (cnt_rd)       rd_data = 16'(count);
    else if (stat_rd) rd_data = {12'd0, overflow, bus.busy, full, empty};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack_r       <= 1'b0;
      data_read_r <= '0;
    end else begin
      ack_r       <= cpu_hit;
      data_read_r <= rd_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      u_lds_r  <= 1'b0;
      u_data_r <= '0;
    end else begin
      state   <= state_nxt;
      u_lds_r <= lds_nxt;
      if (load_head) u_data_r <= {mem[rd_ptr], 8'h00};
    end
  end

  // u_lds rises one cycle after entering REQ and is dropped on the acking edge;
  // GAP then keeps it low for a full cycle before the next request.
  always_comb begin
    state_nxt = state;
    load_head = 1'b0;
    lds_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (~empty & ~flush) begin
          load_head = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (u_lds_r & bus.u_ack) state_nxt = GAP;
        else                     lds_nxt   = 1'b1;
      end
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.data_read    = data_read_r;
  assign bus.ack          = ack_r;
  assign bus.u_data_write = u_data_r;
  assign bus.u_addr       = UART_TX_ADDR;
  assign bus.u_uds        = 1'b0;
  assign bus.u_lds        = u_lds_r;
  assign bus.u_rw         = 1'b0;
  assign bus.fifo_empty   = empty;
  assign bus.busy         = ~empty | (state != IDLE);
endmodule

// File: tb/tb_uart_tx_buffer.sv
// Scoreboard bench for uart_tx_buffer: stimulus queues expected CPU read data
// and drained bytes; monitor processes compare whenever ack or a uart handshake occurs.
module tb_uart_tx_buffer;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_tx_buffer_if bus ();

  uart_tx_buffer #(.DEPTH_LOG2(4), .UART_TX_ADDR(8'h02)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          total = 0;
  int          bad   = 0;
  logic [15:0] cpu_q[$];
  logic [7:0]  drain_q[$];
  logic        uart_auto = 1'b0;
  logic        man_ack   = 1'b0;
  logic        model_ack = 1'b0;
  logic        rand_delay = 1'b0;
  int          ack_delay = 3;
  int          wait_cnt  = 0;

  assign bus.u_ack = uart_auto ? model_ack : man_ack;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // uart model: acks a pending request after ack_delay cycles, for one cycle
  initial begin
    forever begin
      @(negedge clk);
      if (model_ack) model_ack = 1'b0;
      else if (uart_auto && bus.u_lds) begin
        if (wait_cnt >= ack_delay) begin
          model_ack = 1'b1;
          wait_cnt  = 0;
          if (rand_delay) ack_delay = $urandom_range(0, 20);
        end else wait_cnt++;
      end
    end
  end

  // monitor: CPU acks and drain handshakes
  initial begin
    logic prev_acc;
    prev_acc = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (reset) prev_acc = 1'b0;
      else begin
        if (bus.ack) begin
          if (cpu_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_ack: ack=1 with no access pending");
          end else check("data_read", bus.data_read, cpu_q.pop_front());
        end
        if (prev_acc) check("gap_after_ack", bus.u_lds, 0);
        prev_acc = bus.u_lds && bus.u_ack;
        if (prev_acc) begin
          if (drain_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_drain: byte %0h sent, none expected", bus.u_data_write);
          end else check("drain_byte", bus.u_data_write, {drain_q.pop_front(), 8'h00});
          check("drain_addr", {bus.u_addr, bus.u_uds, bus.u_rw}, {8'h02, 2'b00});
        end
      end
    end
  end

  task automatic cpu(input logic rw_i, input logic [7:0] a, input logic [15:0] d,
                     input logic [15:0] exp);
    @(negedge clk);
    bus.rw = rw_i; bus.addr = a; bus.data_write = d; bus.lds = 1'b1; bus.uds = 1'b0;
    cpu_q.push_back(exp);
    @(negedge clk);
    bus.lds = 1'b0; bus.rw = 1'b1;
  endtask

  task automatic push_byte(input logic [7:0] b, input bit accepted_and_sent);
    if (accepted_and_sent) drain_q.push_back(b);
    cpu(1'b0, 8'h03, {b, 8'h00}, 16'h0000);
  endtask

  task automatic wait_idle(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      #2;
      if (!bus.busy && drain_q.size() == 0) break;
    end
    check("idle_busy", bus.busy, 0);
    check("idle_drain_left", drain_q.size(), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    reset = 1'b1;
    bus.lds = 1'b0; bus.uds = 1'b0; bus.rw = 1'b1; bus.addr = 8'h00; bus.data_write = 16'h0000;
    repeat (3) @(negedge clk);
    #2;
    check("rst_data_read", bus.data_read, 0);
    check("rst_ack", bus.ack, 0);
    check("rst_u_lds", bus.u_lds, 0);
    check("rst_u_data", bus.u_data_write, 0);
    check("rst_u_addr", bus.u_addr, 8'h02);
    check("rst_empty", bus.fifo_empty, 1);
    check("rst_busy", bus.busy, 0);
    @(negedge clk);
    reset = 1'b0;

    // single byte, uart acks 3 cycles after the request
    uart_auto = 1'b1; ack_delay = 3;
    push_byte(8'h41, 1);
    @(negedge clk); #2;
    check("lat_lds_early", bus.u_lds, 0);
    @(negedge clk); #2;
    check("lat_lds", bus.u_lds, 1);
    check("lat_data", bus.u_data_write, 16'h4100);
    wait_idle(100);
    check("t1_empty", bus.fifo_empty, 1);

    // fill to 16 with uart stalled, overflow on 17th
    uart_auto = 1'b0; man_ack = 1'b0;
    for (int i = 0; i < 16; i++) push_byte(8'(i), 1);
    cpu(1'b1, 8'h05, 16'h0000, 16'h0010);
    push_byte(8'hAA, 0);
    cpu(1'b1, 8'h07, 16'h0000, 16'h000E);
    cpu(1'b1, 8'h07, 16'h0000, 16'h0006);

    // full FIFO: push coincides with drain pop
    @(negedge clk);
    bus.rw = 1'b0; bus.addr = 8'h03; bus.data_write = 16'h5500; bus.lds = 1'b1;
    man_ack = 1'b1;
    cpu_q.push_back(16'h0000);
    drain_q.push_back(8'h55);
    @(negedge clk);
    bus.lds = 1'b0; bus.rw = 1'b1; man_ack = 1'b0;
    cpu(1'b1, 8'h05, 16'h0000, 16'h0010);
    ack_delay = 0; uart_auto = 1'b1;
    wait_idle(2000);
    cpu(1'b1, 8'h07, 16'h0000, 16'h0001);

    // flush while a request is in flight
    uart_auto = 1'b0;
    push_byte(8'h10, 1);
    for (int i = 1; i < 5; i++) push_byte(8'(8'h10 + i), 0);
    cpu(1'b0, 8'h07, 16'h0100, 16'h0000);
    cpu(1'b1, 8'h05, 16'h0000, 16'h0000);
    @(negedge clk); man_ack = 1'b1;
    @(negedge clk); man_ack = 1'b0;
    repeat (6) @(negedge clk);
    #2;
    check("flush_no_lds", bus.u_lds, 0);
    check("flush_busy", bus.busy, 0);
    check("flush_empty", bus.fifo_empty, 1);
    check("flush_drain_left", drain_q.size(), 0);

    // async reset during REQ
    for (int i = 0; i < 3; i++) push_byte(8'(8'h20 + i), 0);
    repeat (2) @(negedge clk);
    #2;
    check("pre_rst_lds", bus.u_lds, 1);
    #1 reset = 1'b1;
    #1;
    check("async_rst_lds", bus.u_lds, 0);
    check("async_rst_empty", bus.fifo_empty, 1);
    @(negedge clk);
    reset = 1'b0;
    cpu(1'b1, 8'h05, 16'h0000, 16'h0000);
    cpu(1'b1, 8'h07, 16'h0000, 16'h0001);

    // interleaved pushes against random uart ack delays
    rand_delay = 1'b1; ack_delay = 5; uart_auto = 1'b1;
    for (int i = 0; i < 40; i++) begin
      for (int w = 0; w < 2000 && drain_q.size() >= 16; w++) @(negedge clk);
      b = 8'($urandom);
      push_byte(b, 1);
      repeat ($urandom_range(0, 6)) @(negedge clk);
    end
    wait_idle(5000);
    repeat (3) @(negedge clk);
    check("cpu_q_left", cpu_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_tx_buffer.md
Name: uart_tx_buffer

Overview:
- Transmit-side byte FIFO that sits between the 68k system bus and the uart block, upstream of the uart TX path.
- The CPU writes bytes into the FIFO without polling the uart's tx_active flag.
- The buffer drains itself into the uart by acting as a bus master on the uart register interface, one byte per uart frame.
- It also provides a status register and a fill level to the CPU.

Parameters:
DEPTH_LOG2, 4, log2 of FIFO depth (DEPTH = 2**DEPTH_LOG2 = 16 entries of 8 bits)
UART_TX_ADDR, 8'h02, uart address driven on drain writes (rxtx byte 1/0 word)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
data_write  in  16  CPU write data; byte payload in [15:8]
data_read  out  16  CPU read data, registered
addr  in  8  CPU register address
uds  in  1  upper data strobe
lds  in  1  lower data strobe
rw  in  1  1 = CPU read, 0 = CPU write
ack  out  1  one-cycle registered acknowledge to CPU
u_data_write  out  16  drain data to uart, {byte, 8'h00}
u_addr  out  8  drain address to uart
u_uds  out  1  always 0
u_lds  out  1  drain request strobe
u_rw  out  1  always 0 (write)
u_ack  in  1  uart acknowledge
fifo_empty  out  1  FIFO holds no bytes
busy  out  1  FIFO non-empty or drain in flight

Behaviour:
- Reset (async, immediate): FIFO pointers and count = 0, overflow = 0, FSM = IDLE.
- Reset output values: data_read = 0, ack = 0, u_lds = 0, u_data_write = 0, u_addr = UART_TX_ADDR, fifo_empty = 1, busy = 0.
- Reset asserted mid-drain drops u_lds at once; the uart's in-progress frame is not this block's concern.
- CPU decode: every cycle with uds|lds asserted produces ack = 1 on the next cycle. data_read defaults to 0 in every cycle without a read hit.
  - addr[7:1] = 1, write, lds: push data_write[15:8].
  - addr[7:1] = 2, read, lds: data_read[7:0] = count (DEPTH_LOG2+1 bits, zero-extended).
  - addr[7:1] = 3, read, lds: data_read[7:0] = {4'd0, overflow, busy, full, empty}. The read clears overflow on the following edge.
  - addr[7:1] = 3, write, lds, data_write[8] = 1: flush, i.e. pointers and count = 0.
  - All other addresses/strobes: ack only, no effect.
- CPU strobes are level-sensitive. The CPU deasserts the strobe after ack; a strobe held across two cycles pushes twice. This is a bus-protocol requirement, not a checked condition.
- Push when full:
  - Byte is dropped and overflow is set (sticky); ack is still given.
  - Exception: if a drain pop occurs in the same cycle, the push is accepted and count stays at DEPTH.
- Push and pop in the same cycle with 0 < count < DEPTH: count unchanged; both pointers advance modulo DEPTH.
- Pointers are DEPTH_LOG2 bits and wrap naturally. full = (count == DEPTH).
- Drain FSM:
  - IDLE: if count != 0 and no flush this cycle, latch the head byte into u_data_write[15:8] and go to REQ.
  - REQ: u_lds = 1, held until u_ack = 1. On u_ack: pop (ignored if count == 0, e.g. after a flush), u_lds = 0 registered, go to GAP.
  - GAP: one cycle with u_lds = 0, so that the uart's level-sensitive decode cannot start a second frame. Then go to IDLE.
- Drain latency: the first byte written into an empty FIFO reaches u_lds = 1 two cycles after the CPU write edge.
- The uart withholds u_ack while transmitting, so REQ naturally stalls for one frame time; the FSM has no timeout.
- A flush during REQ does not abort the in-flight request; the latched byte is still sent.
- busy = (count != 0) | (state != IDLE).

Test Plan:
- Reset, then a CPU write to addr 8'h03 with lds, data_write = 16'h4100 -> ack next cycle; u_lds high two cycles after the write with u_data_write = 16'h4100, u_addr = 8'h02. Model u_ack after 3 cycles -> u_lds low, one GAP cycle, busy = 0, fifo_empty = 1.
- Write bytes 0x00..0x0F while holding u_ack = 0 -> count read (addr 8'h05) returns 16, full = 1. A 17th write (0xAA) is dropped; status read (addr 8'h07) = 8'h0E. A second status read = 8'h06 (overflow cleared).
- With a 16-byte FIFO full, in REQ, assert u_ack in the same cycle as a CPU push of 0x55 -> push accepted, count stays 16. Drain all bytes -> order is 0x01..0x0F then 0x55, confirming pointer wrap.
- Fill 5 bytes, then write flush (addr 8'h07, data_write = 16'h0100) while in REQ -> in-flight byte still sent on u_ack, no pop underflow, count = 0, no further u_lds pulses.
- Assert reset during REQ with 3 bytes queued -> u_lds = 0 in the same cycle (async); after release, count = 0, status = 8'h01.
- Random interleaved CPU pushes and u_ack delays of 0..20 cycles against a scoreboard -> drained sequence equals the accepted pushes; u_lds is never high on two consecutive cycles across an ack.
